// File: rtl/sramc_pkg.sv
// Shared constants for the SRAM controller AHB-Lite front end: bus encodings
// and the one-hot state encoding of the slave FSM.
package sramc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HSIZE_DWORD   = 3'd3;

  localparam int STATE_W = 8;

  localparam logic [STATE_W-1:0] ST_IDLE    = 8'b0000_0001;
  localparam logic [STATE_W-1:0] ST_WR_WAIT = 8'b0000_0010;
  localparam logic [STATE_W-1:0] ST_WR      = 8'b0000_0100;
  localparam logic [STATE_W-1:0] ST_RD      = 8'b0000_1000;
  localparam logic [STATE_W-1:0] ST_RD_WAIT = 8'b0001_0000;
  localparam logic [STATE_W-1:0] ST_RD_DONE = 8'b0010_0000;
  localparam logic [STATE_W-1:0] ST_ERR1    = 8'b0100_0000;
  localparam logic [STATE_W-1:0] ST_ERR2    = 8'b1000_0000;

endpackage

// File: rtl/sramc_lane_decode.sv
// Combinational address-phase decode: byte strobes, SRAM word address and
// the illegal-access flag (oversize, misaligned, or outside the SRAM window).
module sramc_lane_decode
  import sramc_pkg::*;
#(
  parameter int                        AHB_ADDR_WIDTH  = 32,
  parameter int                        DATA_WIDTH      = 32,
  parameter int                        SRAM_ADDR_WIDTH = 12,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic [2:0]                  hsize,
  input  logic [AHB_ADDR_WIDTH-1:0]   haddr,
  output logic [DATA_WIDTH/8-1:0]     be,
  output logic [SRAM_ADDR_WIDTH-1:0]  word_addr,
  output logic                        err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = $clog2(NB);
  // One extra bit so the window end never wraps for windows at the top of the map.
  localparam logic [AHB_ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [AHB_ADDR_WIDTH:0] WIN_HI =
    WIN_LO + ((AHB_ADDR_WIDTH+1)'(NB) << SRAM_ADDR_WIDTH);

  logic [L-1:0]              offset;
  logic [AHB_ADDR_WIDTH-1:0] rel;
  logic [7:0]                size_mask;
  logic [2*NB-1:0]           lanes;

  always_comb begin
    offset    = haddr[L-1:0];
    rel       = haddr - BASE_ADDR;
    word_addr = rel[L +: SRAM_ADDR_WIDTH];
    lanes     = '0;
    for (int i = 0; i < NB; i++) begin
      lanes[i] = (i < (1 << hsize));
    end
    lanes     = lanes << offset;
    be        = lanes[NB-1:0];
    size_mask = 8'((1 << hsize) - 1);
    err       = (hsize > 3'(L))
             || ((8'(offset) & size_mask) != 8'd0)
             || ({1'b0, haddr} <  WIN_LO)
             || ({1'b0, haddr} >= WIN_HI);
  end

endmodule

// File: rtl/sramc_ahb_slave.sv
// AHB-Lite slave front end driving one single-port synchronous SRAM, with
// byte strobes, configurable wait states and a two-cycle ERROR response.
module sramc_ahb_slave
  import sramc_pkg::*;
#(
  parameter int                        AHB_ADDR_WIDTH  = 32,
  parameter int                        DATA_WIDTH      = 32,
  parameter int                        SRAM_ADDR_WIDTH = 12,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                        WAIT_STATES     = 0
) (
  input  logic                        hclk,
  input  logic                        hreset_n,
  input  logic                        hsel,
  input  logic                        hready,
  input  logic                        hwrite,
  input  logic [2:0]                  hsize,
  input  logic [1:0]                  htrans,
  input  logic [AHB_ADDR_WIDTH-1:0]   haddr,
  input  logic [DATA_WIDTH-1:0]       hwdata,
  output logic [DATA_WIDTH-1:0]       hrdata,
  output logic                        hready_resp,
  output logic [1:0]                  hresp,
  output logic                        sram_ce,
  output logic                        sram_we,
  output logic [DATA_WIDTH/8-1:0]     sram_be,
  output logic [SRAM_ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]       sram_wdata,
  input  logic [DATA_WIDTH-1:0]       sram_rdata,
  output logic [STATE_W-1:0]          dbg_state
);

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [STATE_W-1:0]         state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [DATA_WIDTH/8-1:0]    be_q, be_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      hrdata_q, hrdata_d;

  logic [DATA_WIDTH/8-1:0]    lane_be;
  logic [SRAM_ADDR_WIDTH-1:0] lane_addr;
  logic                       lane_err;
  logic                       resolve;
  logic                       accept;
  logic                       unused_htrans0;

  assign unused_htrans0 = htrans[0];

  sramc_lane_decode #(
    .AHB_ADDR_WIDTH  (AHB_ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH),
    .BASE_ADDR       (BASE_ADDR)
  ) u_lane_decode (
    .hsize     (hsize),
    .haddr     (haddr),
    .be        (lane_be),
    .word_addr (lane_addr),
    .err       (lane_err)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    be_d     = be_q;
    addr_d   = addr_q;
    hrdata_d = hrdata_q;
    // States that end a data phase with hready_resp high may take the next address.
    resolve  = (state_q == ST_IDLE) || (state_q == ST_WR)
            || (state_q == ST_RD_DONE) || (state_q == ST_ERR2);
    accept   = resolve && hsel && hready && htrans[1];

    case (state_q)
      ST_WR_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_WR;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RD: begin
        if (WAIT_STATES > 0) begin
          state_d = ST_RD_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_RD_DONE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RD_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RD_DONE: hrdata_d = sram_rdata;
      ST_ERR1:    state_d  = ST_ERR2;
      default: ;
    endcase

    if (resolve) begin
      state_d = ST_IDLE;
      if (accept) begin
        be_d   = lane_be;
        addr_d = lane_addr;
        if (lane_err) begin
          state_d = ST_ERR1;
        end else if (hwrite) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WR_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_WR;
          end
        end else begin
          state_d = ST_RD;
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      hrdata_q <= hrdata_d;
    end
  end

  // SRAM data arrives during RD_DONE, so it is forwarded directly and held afterwards.
  assign hrdata      = (state_q == ST_RD_DONE) ? sram_rdata : hrdata_q;
  assign hready_resp = !((state_q == ST_WR_WAIT) || (state_q == ST_RD)
                      || (state_q == ST_RD_WAIT) || (state_q == ST_ERR1));
  assign hresp       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign sram_ce     = (state_q == ST_WR) || (state_q == ST_RD);
  assign sram_we     = (state_q == ST_WR);
  assign sram_be     = be_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = hwdata;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sramc_ahb_slave.sv
// Directed bench for sramc_ahb_slave: one instance with no wait states and
// one with three, each backed by a behavioural synchronous SRAM.
module tb_sramc_ahb_slave;
  import sramc_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        hclk, hreset_n;
  logic        hsel0, hsel3, hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;

  logic [31:0] hrdata0, hrdata3, wdata0, wdata3, rdata0, rdata3;
  logic        hready_resp0, hready_resp3, ce0, ce3, we0, we3;
  logic [1:0]  hresp0, hresp3;
  logic [3:0]  be0, be3;
  logic [11:0] addr0, addr3;
  logic [7:0]  dbg0, dbg3;

  logic [31:0] mem0 [0:4095];
  logic [31:0] mem3 [0:4095];

  int n_checks = 0;
  int n_fail   = 0;
  int ce_cnt0  = 0, we_cnt0 = 0, ce_cnt3 = 0, we_cnt3 = 0;
  bit use3     = 0;

  logic [31:0] m_hrdata;
  logic        m_ready, m_ce, m_we;
  logic [1:0]  m_hresp;
  logic [3:0]  m_be;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  int          m_ce_cnt;

  assign m_hrdata = use3 ? hrdata3 : hrdata0;
  assign m_ready  = use3 ? hready_resp3 : hready_resp0;
  assign m_ce     = use3 ? ce3 : ce0;
  assign m_we     = use3 ? we3 : we0;
  assign m_hresp  = use3 ? hresp3 : hresp0;
  assign m_be     = use3 ? be3 : be0;
  assign m_addr   = use3 ? addr3 : addr0;
  assign m_wdata  = use3 ? wdata3 : wdata0;
  assign m_ce_cnt = use3 ? ce_cnt3 : ce_cnt0;

  sramc_ahb_slave #(.BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .hready(hready_resp0),
    .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata0), .hready_resp(hready_resp0), .hresp(hresp0),
    .sram_ce(ce0), .sram_we(we0), .sram_be(be0), .sram_addr(addr0),
    .sram_wdata(wdata0), .sram_rdata(rdata0), .dbg_state(dbg0)
  );

  sramc_ahb_slave #(.BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel3), .hready(hready_resp3),
    .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata3), .hready_resp(hready_resp3), .hresp(hresp3),
    .sram_ce(ce3), .sram_we(we3), .sram_be(be3), .sram_addr(addr3),
    .sram_wdata(wdata3), .sram_rdata(rdata3), .dbg_state(dbg3)
  );

  // Clock and behavioural SRAMs
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  always @(posedge hclk) begin
    if (ce0) begin
      ce_cnt0 <= ce_cnt0 + 1;
      if (we0) begin
        we_cnt0 <= we_cnt0 + 1;
        for (int b = 0; b < 4; b++) if (be0[b]) mem0[addr0][8*b +: 8] <= wdata0[8*b +: 8];
      end else begin
        rdata0 <= mem0[addr0];
      end
    end
    if (ce3) begin
      ce_cnt3 <= ce_cnt3 + 1;
      if (we3) begin
        we_cnt3 <= we_cnt3 + 1;
        for (int b = 0; b < 4; b++) if (be3[b]) mem3[addr3][8*b +: 8] <= wdata3[8*b +: 8];
      end else begin
        rdata3 <= mem3[addr3];
      end
    end
  end

  // Driver tasks: callers sit #1 after a rising edge
  task automatic bus_idle();
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                            input logic [1:0] tr);
    if (use3) hsel3 = 1'b1; else hsel0 = 1'b1;
    hwrite = wr; hsize = sz; haddr = a; htrans = tr;
  endtask

  task automatic next_cycle();
    @(posedge hclk); #1;
  endtask

  task automatic data_phase(input string name, input logic is_wr, input int exp_low,
                            input logic [31:0] exp_data, input logic [3:0] exp_be,
                            input logic [11:0] exp_addr);
    int low = 0;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge hclk);
      if (m_ready) begin
        done = 1;
        n_checks++; if (m_hresp !== HRESP_OKAY) begin n_fail++; $display("FAIL %s.hresp: got %b want 00", name, m_hresp); end
        n_checks++; if (m_addr !== exp_addr) begin n_fail++; $display("FAIL %s.sram_addr: got %h want %h", name, m_addr, exp_addr); end
        if (is_wr) begin
          n_checks++; if (m_ce !== 1'b1 || m_we !== 1'b1) begin n_fail++; $display("FAIL %s.ce_we: got %b%b want 11", name, m_ce, m_we); end
          n_checks++; if (m_be !== exp_be) begin n_fail++; $display("FAIL %s.sram_be: got %h want %h", name, m_be, exp_be); end
          n_checks++; if (m_wdata !== exp_data) begin n_fail++; $display("FAIL %s.sram_wdata: got %h want %h", name, m_wdata, exp_data); end
        end else begin
          n_checks++; if (m_hrdata !== exp_data) begin n_fail++; $display("FAIL %s.hrdata: got %h want %h", name, m_hrdata, exp_data); end
          n_checks++; if (m_ce !== 1'b0) begin n_fail++; $display("FAIL %s.ce_done: got %b want 0", name, m_ce); end
        end
      end else begin
        low++;
        if (is_wr) begin
          n_checks++; if (m_ce !== 1'b0) begin n_fail++; $display("FAIL %s.ce_wait: got %b want 0", name, m_ce); end
        end
      end
      next_cycle();
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL %s.timeout: got no hready_resp want ready within 20 cycles", name); end
    n_checks++; if (low != exp_low) begin n_fail++; $display("FAIL %s.wait_cycles: got %0d want %0d", name, low, exp_low); end
  endtask

  task automatic do_write(input string name, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be,
                          input logic [11:0] exp_addr, input int exp_low);
    addr_phase(1'b1, sz, a, HTRANS_NONSEQ);
    next_cycle();
    bus_idle();
    hwdata = d;
    data_phase(name, 1'b1, exp_low, d, exp_be, exp_addr);
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic [11:0] exp_addr, input int exp_low);
    addr_phase(1'b0, HSIZE_WORD, a, HTRANS_NONSEQ);
    next_cycle();
    bus_idle();
    data_phase(name, 1'b0, exp_low, exp_d, 4'h0, exp_addr);
  endtask

  task automatic do_error(input string name, input logic wr, input logic [2:0] sz,
                          input logic [31:0] a);
    int ce_before = m_ce_cnt;
    addr_phase(wr, sz, a, HTRANS_NONSEQ);
    next_cycle();
    bus_idle();
    @(negedge hclk);
    n_checks++; if (m_hresp !== HRESP_ERROR || m_ready !== 1'b0) begin n_fail++; $display("FAIL %s.err1: got hresp=%b ready=%b want 01/0", name, m_hresp, m_ready); end
    next_cycle();
    @(negedge hclk);
    n_checks++; if (m_hresp !== HRESP_ERROR || m_ready !== 1'b1) begin n_fail++; $display("FAIL %s.err2: got hresp=%b ready=%b want 01/1", name, m_hresp, m_ready); end
    next_cycle();
    @(negedge hclk);
    n_checks++; if (m_hresp !== HRESP_OKAY) begin n_fail++; $display("FAIL %s.after: got hresp=%b want 00", name, m_hresp); end
    n_checks++; if (m_ce_cnt != ce_before) begin n_fail++; $display("FAIL %s.no_ce: got %0d accesses want %0d", name, m_ce_cnt, ce_before); end
    next_cycle();
  endtask

  // Scenarios
  task automatic test_reset();
    hreset_n = 1'b0; use3 = 0;
    hsel0 = 1'b1; hsel3 = 1'b0; hwrite = 1'b1; hsize = HSIZE_WORD;
    htrans = HTRANS_NONSEQ; haddr = BASE + 32'h10; hwdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    n_checks++; if (hready_resp0 !== 1'b1 || hresp0 !== 2'b00) begin n_fail++; $display("FAIL reset.resp: got ready=%b hresp=%b want 1/00", hready_resp0, hresp0); end
    n_checks++; if (hrdata0 !== 32'h0) begin n_fail++; $display("FAIL reset.hrdata: got %h want 0", hrdata0); end
    n_checks++; if (ce0 !== 1'b0 || we0 !== 1'b0) begin n_fail++; $display("FAIL reset.ce_we: got %b%b want 00", ce0, we0); end
    n_checks++; if (be0 !== 4'h0 || addr0 !== 12'h0) begin n_fail++; $display("FAIL reset.be_addr: got %h/%h want 0/0", be0, addr0); end
    n_checks++; if (dbg0 !== ST_IDLE) begin n_fail++; $display("FAIL reset.state: got %b want %b", dbg0, ST_IDLE); end
    n_checks++; if (ce_cnt0 != 0) begin n_fail++; $display("FAIL reset.no_ce: got %0d want 0", ce_cnt0); end
    next_cycle();
    bus_idle();
    hreset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_read();
    do_write("wr_word", HSIZE_WORD, BASE + 32'h10, 32'hA5A5_5A5A, 4'hF, 12'h004, 0);
    do_read("rd_word", BASE + 32'h10, 32'hA5A5_5A5A, 12'h004, 1);
    @(negedge hclk);
    n_checks++; if (hrdata0 !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL rd_hold: got %h want a5a55a5a", hrdata0); end
    next_cycle();
    do_write("wr_top", HSIZE_WORD, BASE + 32'h3FFC, 32'h0BAD_F00D, 4'hF, 12'hFFF, 0);
    do_read("rd_top", BASE + 32'h3FFC, 32'h0BAD_F00D, 12'hFFF, 1);
  endtask

  task automatic test_byte_lanes();
    do_write("wr_byte", HSIZE_BYTE, BASE + 32'h13, 32'h3C00_0000, 4'h8, 12'h004, 0);
    do_write("wr_half", HSIZE_HALF, BASE + 32'h12, 32'hBEEF_0000, 4'hC, 12'h004, 0);
    do_read("rd_lanes", BASE + 32'h10, 32'hBEEF_5A5A, 12'h004, 1);
  endtask

  task automatic test_errors();
    do_error("err_window", 1'b0, HSIZE_WORD, BASE + 32'h4000);
    do_error("err_misalign", 1'b0, HSIZE_HALF, BASE + 32'h1);
    do_error("err_below", 1'b1, HSIZE_WORD, BASE - 32'h4);
    do_error("err_oversize", 1'b1, HSIZE_DWORD, BASE + 32'h8);
  endtask

  task automatic test_back_to_back();
    use3 = 1;
    addr_phase(1'b1, HSIZE_WORD, BASE + 32'h20, HTRANS_NONSEQ);
    next_cycle();
    htrans = HTRANS_BUSY;
    hwdata = 32'h1234_5678;
    data_phase("b2b_wr", 1'b1, 3, 32'h1234_5678, 4'hF, 12'h008);
    addr_phase(1'b0, HSIZE_WORD, BASE + 32'h20, HTRANS_SEQ);
    @(negedge hclk);
    n_checks++; if (hready_resp3 !== 1'b1 || hresp3 !== HRESP_OKAY) begin n_fail++; $display("FAIL b2b_busy: got ready=%b hresp=%b want 1/00", hready_resp3, hresp3); end
    next_cycle();
    bus_idle();
    data_phase("b2b_rd", 1'b0, 4, 32'h1234_5678, 4'h0, 12'h008);
  endtask

  task automatic test_reset_mid_write();
    int we_before;
    use3 = 1;
    we_before = we_cnt3;
    addr_phase(1'b1, HSIZE_WORD, BASE + 32'h30, HTRANS_NONSEQ);
    next_cycle();
    bus_idle();
    hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    n_checks++; if (dbg3 !== ST_WR_WAIT || hready_resp3 !== 1'b0) begin n_fail++; $display("FAIL rst_mid.wait: got state=%b ready=%b want %b/0", dbg3, hready_resp3, ST_WR_WAIT); end
    next_cycle();
    hreset_n = 1'b0;
    #1;
    n_checks++; if (hready_resp3 !== 1'b1 || hresp3 !== 2'b00) begin n_fail++; $display("FAIL rst_mid.resp: got ready=%b hresp=%b want 1/00", hready_resp3, hresp3); end
    n_checks++; if (ce3 !== 1'b0 || we3 !== 1'b0 || be3 !== 4'h0 || addr3 !== 12'h0) begin n_fail++; $display("FAIL rst_mid.sram: got ce=%b we=%b be=%h addr=%h want 0/0/0/0", ce3, we3, be3, addr3); end
    repeat (2) next_cycle();
    hreset_n = 1'b1;
    repeat (6) next_cycle();
    n_checks++; if (we_cnt3 != we_before) begin n_fail++; $display("FAIL rst_mid.no_write: got %0d writes want %0d", we_cnt3, we_before); end
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
